// File: rtl/t_ff_updown_counter_pkg.sv
// Shared definitions for the toggle-flop up/down counter.
// Direction encoding and the load-value clamp.
package t_counter_pkg;

    localparam logic COUNT_UP   = 1'b1;
    localparam logic COUNT_DOWN = 1'b0;

    // Out-of-range load values saturate to the top of the count range.
    function automatic logic [31:0] clamp_load(
        input logic [31:0] d,
        input int          modulus
    );
        logic [31:0] top;
        top = 32'(modulus - 1);
        return (d < top) ? d : top;
    endfunction

endpackage

// File: rtl/t_ff_updown_counter_t_flip_flop.sv
// Single-bit edge-triggered toggle flip-flop.
// Asynchronous active-high reset clears the bit.
module t_flip_flop (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic Q,
    output logic Qn
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

    assign Qn = ~Q;

endmodule

// File: rtl/t_ff_updown_counter.sv
// Modulo-N up/down counter: toggle-vector logic over WIDTH T flip-flops,
// with parallel load, hold, terminal count and a registered wrap pulse.
module t_ff_updown_counter
    import t_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic             TC,
    output logic             WRAP
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] dc;
    logic             at_max;
    logic             at_zero;
    logic             wrap_next;
    logic             carry;

    assign dc      = WIDTH'(clamp_load(32'(D), MODULUS));
    assign at_max  = (Q == MAX);
    assign at_zero = (Q == '0);

    always_comb begin
        t         = '0;
        wrap_next = 1'b0;
        carry     = 1'b1;
        if (LOAD) begin
            t = Q ^ dc;
        end else if (EN) begin
            unique case (UP)
                COUNT_UP: begin
                    if (at_max) begin
                        t         = Q;
                        wrap_next = 1'b1;
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            t[i]  = carry;
                            carry = carry & Q[i];
                        end
                    end
                end
                COUNT_DOWN: begin
                    if (at_zero) begin
                        t         = MAX;
                        wrap_next = 1'b1;
                    end else begin
                        // Borrow ripples through trailing zeros
                        for (int i = 0; i < WIDTH; i++) begin
                            t[i]  = carry;
                            carry = carry & ~Q[i];
                        end
                    end
                end
                default: t = '0;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_flip_flop u_tff (
            .clk (clk),
            .rst (rst),
            .T   (t[i]),
            .Q   (Q[i]),
            .Qn  (Qn[i])
        );
    end

    assign TC = EN & ~LOAD & ((UP == COUNT_UP) ? at_max : at_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= wrap_next;
        end
    end

endmodule

// File: tb/tb_t_ff_updown_counter.sv
// Self-checking bench for t_ff_updown_counter (WIDTH=4, MODULUS=10):
// vector table, directed corner sequences and randomized model comparison.
module tb_t_ff_updown_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         EN;
    logic         UP;
    logic         LOAD;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic         TC;
    logic         WRAP;

    int checks = 0;
    int errors = 0;
    int mq     = 0;

    t_ff_updown_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .clk  (clk),
        .rst  (rst),
        .EN   (EN),
        .UP   (UP),
        .LOAD (LOAD),
        .D    (D),
        .Q    (Q),
        .Qn   (Qn),
        .TC   (TC),
        .WRAP (WRAP)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit ld;
        bit en;
        bit up;
        int d;
        int eq;
        bit ew;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference behaviour in plain modular arithmetic.
    function automatic int model_next(int q, bit ld, bit en, bit up, int d);
        if (ld) return (d < M) ? d : M - 1;
        if (!en) return q;
        return up ? (q + 1) % M : (q + M - 1) % M;
    endfunction

    function automatic bit model_wrap(int q, bit ld, bit en, bit up);
        if (ld || !en) return 1'b0;
        return up ? (q == M - 1) : (q == 0);
    endfunction

    function automatic bit model_tc(int q, bit ld, bit en, bit up);
        return en && !ld && (up ? (q == M - 1) : (q == 0));
    endfunction

    task automatic tick(input string nm);
        int eq;
        bit ew;
        eq = model_next(mq, LOAD, EN, UP, int'(D));
        ew = model_wrap(mq, LOAD, EN, UP);
        if (rst) begin
            eq = 0;
            ew = 1'b0;
        end
        @(posedge clk);
        #1;
        mq = eq;
        chk({nm, "_q"}, int'(Q), eq);
        chk({nm, "_qn"}, int'(Qn), (~eq) & 15);
        chk({nm, "_wrap"}, int'(WRAP), int'(ew));
        chk({nm, "_tc"}, int'(TC), int'(model_tc(mq, LOAD, EN, UP)));
    endtask

    // Pulse rst between edges; Q must clear before the next edge.
    task automatic async_reset(input string nm);
        #3;
        rst = 1'b1;
        #1;
        chk({nm, "_q"}, int'(Q), 0);
        chk({nm, "_qn"}, int'(Qn), 15);
        chk({nm, "_wrap"}, int'(WRAP), 0);
        #1;
        rst = 1'b0;
        mq  = 0;
    endtask

    initial begin
        rst  = 1'b1;
        EN   = 1'b1;
        UP   = 1'b1;
        LOAD = 1'b0;
        D    = '0;
        #1;
        chk("reset_q0", int'(Q), 0);
        chk("reset_qn0", int'(Qn), 15);
        chk("reset_wrap0", int'(WRAP), 0);
        for (int i = 0; i < 3; i++) tick("reset_hold");
        rst = 1'b0;
        mq  = 0;

        // Up count mod 10
        for (int i = 0; i < 12; i++) tick("up");

        // Down count from reset
        async_reset("rst_dn");
        UP = 1'b0;
        for (int i = 0; i < 12; i++) tick("down");

        // Hold and direction change
        async_reset("rst_hold");
        UP = 1'b1;
        for (int i = 0; i < 5; i++) tick("to5");
        chk("at5", int'(Q), 5);
        EN = 1'b0;
        for (int i = 0; i < 4; i++) tick("hold");
        chk("held5", int'(Q), 5);
        EN = 1'b1;
        UP = 1'b0;
        tick("dn4");
        tick("dn3");
        chk("at3", int'(Q), 3);
        UP = 1'b1;
        tick("flip4");
        chk("at4", int'(Q), 4);

        // Async reset mid-count then resume
        async_reset("rst_pre");
        for (int i = 0; i < 6; i++) tick("to6");
        chk("at6", int'(Q), 6);
        async_reset("rst_mid");
        for (int i = 0; i < 3; i++) tick("resume");
        chk("resumed3", int'(Q), 3);

        // Vector table, starting from Q=0
        async_reset("rst_tbl");
        tbl = '{
            '{1, 1, 1,  7, 7, 0},
            '{0, 1, 1,  0, 8, 0},
            '{0, 1, 1,  0, 9, 0},
            '{0, 1, 1,  0, 0, 1},
            '{0, 1, 1,  0, 1, 0},
            '{1, 0, 0, 12, 9, 0},
            '{0, 0, 1,  0, 9, 0},
            '{0, 1, 0,  0, 8, 0},
            '{1, 1, 0,  9, 9, 0},
            '{0, 1, 1,  0, 0, 1},
            '{0, 1, 0,  0, 9, 1},
            '{1, 1, 1,  0, 0, 0},
            '{0, 1, 0,  0, 9, 1},
            '{1, 0, 1, 15, 9, 0}
        };
        foreach (tbl[i]) begin
            LOAD = tbl[i].ld;
            EN   = tbl[i].en;
            UP   = tbl[i].up;
            D    = W'(tbl[i].d);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_q", i), int'(Q), tbl[i].eq);
            chk($sformatf("tbl%0d_wrap", i), int'(WRAP), int'(tbl[i].ew));
            mq = tbl[i].eq;
        end

        // Randomized against the model
        for (int i = 0; i < 400; i++) begin
            EN   = ($urandom_range(0, 3) != 0);
            UP   = $urandom_range(0, 1) != 0;
            LOAD = ($urandom_range(0, 7) == 0);
            D    = W'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) async_reset("rnd_rst");
            tick("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
